// File: rtl/stream_crc_checker_if.sv
// rtl/stream_crc_checker_if.sv - AXI-stream style bus observed by the CRC checker
interface stream_crc_checker_if #(
    parameter int DSIZE = 32
) ();
    logic [DSIZE-1:0]   tdata;
    logic [DSIZE/8-1:0] tkeep;
    logic               tvalid;
    logic               tready;
    logic               tlast;

    modport master  (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave   (input tdata, tkeep, tvalid, tlast, output tready);
    // Passive tap: every signal is an input, including tready.
    modport monitor (input tdata, tkeep, tvalid, tready, tlast);
endinterface

// File: rtl/stream_crc_checker.sv
// rtl/stream_crc_checker.sv - passive per-packet CRC-32 checker; optional stats via STREAM_CRC_CHECKER_STAT_EN
module stream_crc_checker #(
    parameter int          DSIZE   = 32,
    parameter logic [31:0] POLY    = 32'hEDB88320,
    parameter logic [31:0] INIT    = 32'hFFFFFFFF,
    parameter logic [31:0] XOROUT  = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
    parameter int          MIN_LEN = 5,
    parameter int          CNT_W   = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    stream_crc_checker_if.monitor s,
`ifdef STREAM_CRC_CHECKER_STAT_EN
    input  logic                 stat_clr,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     err_cnt,
`endif
    output logic [31:0]          crc,
    output logic [15:0]          crc_fold,
    output logic                 crc_valid,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic                 runt,
    output logic                 busy
);
    localparam int          KSIZE     = DSIZE / 8;
    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);

    typedef enum logic {IDLE, IN_PKT} state_t;

    state_t      state;
    logic [31:0] crc_reg;
    logic [15:0] byte_cnt;

    logic        beat;
    logic [31:0] reg_next;
    logic [15:0] cnt_next;
    logic [31:0] crc_out_next;
    logic        good_next;
    logic        runt_next;

    assign beat = s.tvalid && s.tready;
    assign busy = (state == IN_PKT);

    // In IDLE the incoming beat is a first beat, so it folds into a fresh INIT seed.
    always_comb begin
        reg_next = (state == IDLE) ? INIT : crc_reg;
        cnt_next = (state == IDLE) ? 16'd0 : byte_cnt;
        for (int i = 0; i < KSIZE; i++) begin
            if (s.tkeep[i]) begin
                reg_next = reg_next ^ {24'd0, s.tdata[8*i +: 8]};
                for (int b = 0; b < 8; b++) begin
                    reg_next = reg_next[0] ? ((reg_next >> 1) ^ POLY) : (reg_next >> 1);
                end
                if (cnt_next != 16'hFFFF) begin
                    cnt_next = cnt_next + 16'd1;
                end
            end
        end
        crc_out_next = reg_next ^ XOROUT;
        runt_next    = (cnt_next < MIN_LEN_W);
        good_next    = (reg_next == RESIDUE) && !runt_next;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            byte_cnt  <= 16'd0;
            crc       <= 32'd0;
            crc_fold  <= 16'd0;
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            runt      <= 1'b0;
        end else begin
            crc_valid <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            if (beat) begin
                if (s.tlast) begin
                    state     <= IDLE;
                    crc_reg   <= INIT;
                    byte_cnt  <= 16'd0;
                    crc       <= crc_out_next;
                    crc_fold  <= crc_out_next[31:16] + crc_out_next[15:0];
                    crc_valid <= 1'b1;
                    crc_ok    <= good_next;
                    crc_err   <= !good_next;
                    runt      <= runt_next;
                end else begin
                    state    <= IN_PKT;
                    crc_reg  <= reg_next;
                    byte_cnt <= cnt_next;
                end
            end
        end
    end

`ifdef STREAM_CRC_CHECKER_STAT_EN
    // Counters follow the registered pulses, so a clear in the pulse cycle beats its increment.
    always_ff @(posedge clock) begin
        if (rst || stat_clr) begin
            pkt_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (crc_valid && (pkt_cnt != {CNT_W{1'b1}})) begin
                pkt_cnt <= pkt_cnt + 1'b1;
            end
            if (crc_err && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_crc_checker.sv
// tb/tb_stream_crc_checker.sv - directed-vector bench for stream_crc_checker
module tb_stream_crc_checker;
    logic        clock;
    logic        rst;
    logic [31:0] crc;
    logic [15:0] crc_fold;
    logic        crc_valid;
    logic        crc_ok;
    logic        crc_err;
    logic        runt;
    logic        busy;
`ifdef STREAM_CRC_CHECKER_STAT_EN
    logic        stat_clr;
    logic [15:0] pkt_cnt;
    logic [15:0] err_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    logic [31:0] good_d [4];
    logic [3:0]  good_k [4];

    stream_crc_checker_if #(.DSIZE(32)) bus ();

    stream_crc_checker dut (
        .clock     (clock),
        .rst       (rst),
        .s         (bus),
`ifdef STREAM_CRC_CHECKER_STAT_EN
        .stat_clr  (stat_clr),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
`endif
        .crc       (crc),
        .crc_fold  (crc_fold),
        .crc_valid (crc_valid),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .runt      (runt),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (crc_valid) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        bus.tdata  = d;
        bus.tkeep  = k;
        bus.tlast  = l;
        bus.tvalid = 1'b1;
        @(posedge clock);
        #1;
        bus.tvalid = 1'b0;
    endtask

    task automatic send_good(input int max_gap);
        for (int i = 0; i < 4; i++) begin
            if (max_gap > 0) idle_cycles($urandom_range(max_gap, 0));
            send(good_d[i], good_k[i], i == 3);
        end
    endtask

    task automatic expect_good(input string tag);
        check({tag, ".valid"}, 32'(crc_valid), 32'd1);
        check({tag, ".crc"},   crc,            32'h2144DF1C);
        check({tag, ".fold"},  32'(crc_fold),  32'h00000060);
        check({tag, ".ok"},    32'(crc_ok),    32'd1);
        check({tag, ".err"},   32'(crc_err),   32'd0);
        check({tag, ".runt"},  32'(runt),      32'd0);
    endtask

    initial begin
        int p0;
        good_d[0] = 32'h34333231; good_k[0] = 4'b1111;
        good_d[1] = 32'h38373635; good_k[1] = 4'b1111;
        good_d[2] = 32'hF4392639; good_k[2] = 4'b1111;
        good_d[3] = 32'h000000CB; good_k[3] = 4'b0001;

        bus.tdata = '0; bus.tkeep = '0; bus.tlast = 1'b0;
        bus.tvalid = 1'b0; bus.tready = 1'b1;
`ifdef STREAM_CRC_CHECKER_STAT_EN
        stat_clr = 1'b0;
`endif
        rst = 1'b1;
        idle_cycles(2);
        rst = 1'b0;

        check("rst.crc",   crc,            32'd0);
        check("rst.fold",  32'(crc_fold),  32'd0);
        check("rst.valid", 32'(crc_valid), 32'd0);
        check("rst.ok",    32'(crc_ok),    32'd0);
        check("rst.err",   32'(crc_err),   32'd0);
        check("rst.runt",  32'(runt),      32'd0);
        check("rst.busy",  32'(busy),      32'd0);

        // Good packet, continuous beats; pulse lands the cycle after tlast.
        for (int i = 0; i < 3; i++) send(good_d[i], good_k[i], 1'b0);
        check("s1.nopulse", 32'(crc_valid), 32'd0);
        send(good_d[3], good_k[3], 1'b1);
        expect_good("s1");
        idle_cycles(1);
        check("s1.pulse_end", 32'(crc_valid), 32'd0);
        check("s1.hold",      crc,            32'h2144DF1C);

        // Corrupted byte 3.
        send(32'h00333231, 4'b1111, 1'b0);
        send(good_d[1], good_k[1], 1'b0);
        send(good_d[2], good_k[2], 1'b0);
        send(good_d[3], good_k[3], 1'b1);
        check("s2.valid", 32'(crc_valid), 32'd1);
        check("s2.err",   32'(crc_err),   32'd1);
        check("s2.ok",    32'(crc_ok),    32'd0);
        idle_cycles(1);
`ifdef STREAM_CRC_CHECKER_STAT_EN
        check("s2.err_cnt", 32'(err_cnt), 32'd1);
        check("s2.pkt_cnt", 32'(pkt_cnt), 32'd2);
`endif

        // Stalls, valid gaps and an empty-keep beat mid-packet.
        send(good_d[0], good_k[0], 1'b0);
        check("s3.busy_first", 32'(busy), 32'd1);
        idle_cycles(2);
        bus.tready = 1'b0;
        bus.tdata = good_d[1]; bus.tkeep = good_k[1]; bus.tlast = 1'b0; bus.tvalid = 1'b1;
        idle_cycles(3);
        check("s3.busy_stall", 32'(busy),      32'd1);
        check("s3.stall_np",   32'(crc_valid), 32'd0);
        bus.tready = 1'b1;
        idle_cycles(1);
        bus.tvalid = 1'b0;
        send(32'hDEADBEEF, 4'b0000, 1'b0);
        idle_cycles(1);
        send(good_d[2], good_k[2], 1'b0);
        idle_cycles(3);
        check("s3.busy_pre", 32'(busy), 32'd1);
        send(good_d[3], good_k[3], 1'b1);
        expect_good("s3");
        check("s3.busy_end", 32'(busy), 32'd0);

        // Random gaps between beats.
        send_good(3);
        expect_good("gap");

        // Sparse keep with junk in skipped lanes.
        send(32'hAA32AA31, 4'b0101, 1'b0);
        send(32'h36353433, 4'b1111, 1'b0);
        send(32'h39AA3837, 4'b1011, 1'b0);
        send(32'hCBF43926, 4'b1111, 1'b1);
        expect_good("sparse");

        // Single-beat runt directly followed by a good packet.
        send(32'h00333231, 4'b0111, 1'b1);
        check("s4.valid", 32'(crc_valid), 32'd1);
        check("s4.err",   32'(crc_err),   32'd1);
        check("s4.runt",  32'(runt),      32'd1);
        check("s4.busy",  32'(busy),      32'd0);
        send_good(0);
        expect_good("s4b");

        // Reset mid-packet.
        send(good_d[0], good_k[0], 1'b0);
        send(good_d[1], good_k[1], 1'b0);
        p0 = pulses;
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check("s5.busy", 32'(busy), 32'd0);
        send_good(0);
        expect_good("s5");
        idle_cycles(1);
        check("s5.pulses", 32'(pulses - p0), 32'd1);
`ifdef STREAM_CRC_CHECKER_STAT_EN
        check("s5.pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Saturation, then clear against a same-cycle crc_err.
        bus.tdata = 32'h00000031; bus.tkeep = 4'b0001; bus.tlast = 1'b1; bus.tvalid = 1'b1;
        repeat (65539) @(posedge clock);
        #1;
        bus.tvalid = 1'b0;
        idle_cycles(2);
        check("s6.err_sat", 32'(err_cnt), 32'h0000FFFF);
        check("s6.pkt_sat", 32'(pkt_cnt), 32'h0000FFFF);
        send(32'h00000031, 4'b0001, 1'b1);
        check("s6.err_pulse", 32'(crc_err), 32'd1);
        stat_clr = 1'b1;
        idle_cycles(1);
        stat_clr = 1'b0;
        check("s6.err_clr", 32'(err_cnt), 32'd0);
        check("s6.pkt_clr", 32'(pkt_cnt), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
